// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//
// Shares one single-ported word memory between an instruction-fetch port (I,
// read-only) and a data load/store port (D, read/write). One transaction is
// in flight at a time. Each memory access is guarded by a timeout, and the
// winning requester gets its read data plus a one-cycle acknowledge.
//
// Optional build macro:
//   MEM_ARB_ROUND_ROBIN_EN - when both requesters are high in IDLE, the one
//                            that did not win the previous grant wins.
//                            Without it, D always beats I.
//
// Ports:
//   clk, reset             clock; asynchronous active-high reset
//   i_req/i_addr           fetch request (held until i_ack) and byte address
//   i_rdata/i_ack          fetched word and one-cycle completion pulse
//   d_req/d_we/d_addr      data request (held until d_ack), 1=store, address
//   d_wdata                store data
//   d_rdata/d_ack          load data and one-cycle completion pulse
//   err                    pulses with an ack when the transaction failed
//                          (misaligned address or memory timeout)
//   mem_req/mem_we         memory strobe (held until mem_ready or abort), write
//   mem_addr/mem_wdata     memory byte address and write data
//   mem_rdata/mem_ready    memory read data and completion
//
// Handshake: a requester raises req with its address/data and holds it until
// its ack pulse. Address and data are latched at grant, so later changes to
// them have no effect. On the memory side, mem_req stays high with stable
// mem_we/mem_addr/mem_wdata until an edge where mem_ready=1 or the timeout
// fires. mem_ready is ignored while mem_req=0.
module mem_port_arbiter #(
   parameter int ADDR_W  = 32,
   parameter int DATA_W  = 32,
   parameter int TIMEOUT = 15
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              i_req,
   input  logic [ADDR_W-1:0] i_addr,
   output logic [DATA_W-1:0] i_rdata,
   output logic              i_ack,
   input  logic              d_req,
   input  logic              d_we,
   input  logic [ADDR_W-1:0] d_addr,
   input  logic [DATA_W-1:0] d_wdata,
   output logic [DATA_W-1:0] d_rdata,
   output logic              d_ack,
   output logic              err,
   output logic              mem_req,
   output logic              mem_we,
   output logic [ADDR_W-1:0] mem_addr,
   output logic [DATA_W-1:0] mem_wdata,
   input  logic [DATA_W-1:0] mem_rdata,
   input  logic              mem_ready
);

   localparam int CNT_W = $clog2(TIMEOUT + 1);

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      ACCESS = 2'd1,
      RESP   = 2'd2
   } state_t;

   state_t             state;
   logic               owner_d;   // 1: D owns the current transaction
   logic [CNT_W-1:0]   cnt;       // ACCESS cycles spent without mem_ready
   logic [CNT_W-1:0]   cnt_inc;

   logic               grant_d;
   logic [ADDR_W-1:0]  grant_addr;
   logic               grant_we;
   logic               grant_misaligned;

`ifdef MEM_ARB_ROUND_ROBIN_EN
   logic               last_d;    // 1: D won the previous grant (reset = I)

   // Under contention, the requester that lost last time wins this time.
   always_comb begin
      grant_d = d_req;
      if (d_req && i_req)
         grant_d = !last_d;
   end
`else
   always_comb begin
      grant_d = d_req;
   end
`endif

   assign grant_addr       = grant_d ? d_addr : i_addr;
   assign grant_we         = grant_d & d_we;
   assign grant_misaligned = (grant_addr[1:0] != 2'b00);
   assign cnt_inc          = cnt + 1'b1;

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         state     <= IDLE;
         owner_d   <= 1'b0;
         cnt       <= '0;
         i_rdata   <= '0;
         i_ack     <= 1'b0;
         d_rdata   <= '0;
         d_ack     <= 1'b0;
         err       <= 1'b0;
         mem_req   <= 1'b0;
         mem_we    <= 1'b0;
         mem_addr  <= '0;
         mem_wdata <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
         last_d    <= 1'b0;
`endif
      end else begin
         case (state)
            IDLE: begin
               if (i_req || d_req) begin
                  owner_d <= grant_d;
                  cnt     <= '0;
`ifdef MEM_ARB_ROUND_ROBIN_EN
                  last_d  <= grant_d;
`endif
                  if (grant_misaligned) begin
                     // Rejected without touching memory: straight to RESP.
                     state   <= RESP;
                     err     <= 1'b1;
                     i_rdata <= '0;
                     d_rdata <= '0;
                     if (grant_d) d_ack <= 1'b1;
                     else         i_ack <= 1'b1;
                  end else begin
                     state     <= ACCESS;
                     mem_req   <= 1'b1;
                     mem_we    <= grant_we;
                     mem_addr  <= grant_addr;
                     mem_wdata <= grant_d ? d_wdata : '0;
                  end
               end
            end

            ACCESS: begin
               // mem_ready wins over a timeout that expires on the same edge.
               if (mem_ready) begin
                  state   <= RESP;
                  mem_req <= 1'b0;
                  err     <= 1'b0;
                  if (owner_d) begin
                     d_ack   <= 1'b1;
                     d_rdata <= mem_we ? '0 : mem_rdata;
                  end else begin
                     i_ack   <= 1'b1;
                     i_rdata <= mem_rdata;
                  end
               end else begin
                  cnt <= cnt_inc;
                  if (cnt_inc == CNT_W'(TIMEOUT)) begin
                     state   <= RESP;
                     mem_req <= 1'b0;
                     err     <= 1'b1;
                     i_rdata <= '0;
                     d_rdata <= '0;
                     if (owner_d) d_ack <= 1'b1;
                     else         i_ack <= 1'b1;
                  end
               end
            end

            RESP: begin
               state   <= IDLE;
               i_ack   <= 1'b0;
               d_ack   <= 1'b0;
               err     <= 1'b0;
               i_rdata <= '0;
               d_rdata <= '0;
            end

            default: begin
               state <= IDLE;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Self-checking bench for mem_port_arbiter: requester driver tasks, a
// behavioural memory with configurable wait states, and a scoreboard of
// expected acknowledges and expected memory transactions.
module tb_mem_port_arbiter;

   localparam int AW = 32;
   localparam int DW = 32;
   localparam int TO = 15;

   logic          clk;
   logic          reset;
   logic          i_req;
   logic [AW-1:0] i_addr;
   logic [DW-1:0] i_rdata;
   logic          i_ack;
   logic          d_req;
   logic          d_we;
   logic [AW-1:0] d_addr;
   logic [DW-1:0] d_wdata;
   logic [DW-1:0] d_rdata;
   logic          d_ack;
   logic          err;
   logic          mem_req;
   logic          mem_we;
   logic [AW-1:0] mem_addr;
   logic [DW-1:0] mem_wdata;
   logic [DW-1:0] mem_rdata;
   logic          mem_ready;

   mem_port_arbiter #(.ADDR_W(AW), .DATA_W(DW), .TIMEOUT(TO)) dut (
      .clk       (clk),
      .reset     (reset),
      .i_req     (i_req),
      .i_addr    (i_addr),
      .i_rdata   (i_rdata),
      .i_ack     (i_ack),
      .d_req     (d_req),
      .d_we      (d_we),
      .d_addr    (d_addr),
      .d_wdata   (d_wdata),
      .d_rdata   (d_rdata),
      .d_ack     (d_ack),
      .err       (err),
      .mem_req   (mem_req),
      .mem_we    (mem_we),
      .mem_addr  (mem_addr),
      .mem_wdata (mem_wdata),
      .mem_rdata (mem_rdata),
      .mem_ready (mem_ready)
   );

   // ---------------- clock ----------------
   initial clk = 1'b0;
   always #5 clk = ~clk;

   // ---------------- scoreboard state ----------------
   int checks = 0;
   int errors = 0;

   logic [DW+1:0]  exp_q[$];   // {is_d, err, rdata}
   logic [AW+DW:0] mq[$];      // {we, addr, wdata}
   logic [DW-1:0]  mem_arr[0:255];
   int             wait_states = 0;
   bit             never_ready = 0;

   task automatic check_val(input string tag, input logic [63:0] got, input logic [63:0] exp);
      checks++;
      if (got !== exp) begin
         errors++;
         $display("FAIL %s got=%0h exp=%0h", tag, got, exp);
      end
   endtask

   // ---------------- behavioural memory ----------------
   initial begin
      int             ws_cnt;
      logic [AW+DW:0] cur;
      logic [AW-1:0]  a;
      ws_cnt    = 0;
      cur       = '0;
      mem_ready = 1'b0;
      mem_rdata = '0;
      forever begin
         @(negedge clk);
         if (reset || !mem_req) begin
            mem_ready = 1'b0;
            mem_rdata = '0;
            ws_cnt    = 0;
         end else begin
            if (ws_cnt == 0) begin
               if (mq.size() == 0) check_val("mem_unexpected", 1, 0);
               else cur = mq.pop_front();
            end
            a = cur[AW+DW-1:DW];
            check_val("mem_we", mem_we, cur[AW+DW]);
            check_val("mem_addr", mem_addr, a);
            if (cur[AW+DW]) check_val("mem_wdata", mem_wdata, cur[DW-1:0]);
            if (!never_ready && ws_cnt == wait_states) begin
               mem_ready = 1'b1;
               if (cur[AW+DW]) begin
                  mem_arr[a[9:2]] = cur[DW-1:0];
                  mem_rdata = $urandom;
               end else begin
                  mem_rdata = mem_arr[a[9:2]];
               end
            end else begin
               mem_ready = 1'b0;
               mem_rdata = $urandom;
            end
            ws_cnt++;
         end
      end
   end

   // ---------------- ack monitor ----------------
   initial begin
      logic [DW+1:0] e;
      forever begin
         @(negedge clk);
         if (!reset) begin
            check_val("ack_excl", i_ack & d_ack, 0);
            check_val("err_qual", err & ~(i_ack | d_ack), 0);
            if (i_ack || d_ack) begin
               if (exp_q.size() == 0) begin
                  check_val("ack_unexpected", 1, 0);
               end else begin
                  e = exp_q.pop_front();
                  check_val("ack_owner", d_ack, e[DW+1]);
                  check_val("ack_err", err, e[DW]);
                  check_val("ack_rdata", d_ack ? d_rdata : i_rdata, e[DW-1:0]);
               end
            end
         end
      end
   end

   // ---------------- driver tasks ----------------
   // kind: 0 normal, 1 misaligned, 2 memory never ready (timeout)
   task automatic run_txn(input string tag, input bit is_d, input bit we,
                          input logic [AW-1:0] addr, input logic [DW-1:0] wdata,
                          input int kind, input int ws, input bit drop_early);
      int lat, mreq, exp_lat, exp_mreq;
      bit is_we;
      logic [DW-1:0] exp_rd;
      is_we  = is_d & we;
      lat    = 0;
      mreq   = 0;
      exp_rd = (kind != 0 || is_we) ? '0 : mem_arr[addr[9:2]];
      exp_q.push_back({is_d, (kind != 0), exp_rd});
      if (kind != 1) mq.push_back({is_we, addr, is_we ? wdata : '0});
      wait_states = ws;
      never_ready = (kind == 2);
      case (kind)
         1:       begin exp_lat = 1;      exp_mreq = 0;      end
         2:       begin exp_lat = TO + 1; exp_mreq = TO;     end
         default: begin exp_lat = 2 + ws; exp_mreq = ws + 1; end
      endcase
      @(negedge clk);
      if (is_d) begin
         d_req = 1'b1; d_we = we; d_addr = addr; d_wdata = wdata;
      end else begin
         i_req = 1'b1; i_addr = addr;
      end
      for (int n = 1; n <= 64 && lat == 0; n++) begin
         @(negedge clk);
         if (mem_req) begin
            mreq++;
            // Requester-side changes after grant must not reach memory.
            d_addr = $urandom; d_wdata = $urandom; i_addr = $urandom; d_we = 1'($urandom);
            if (drop_early) begin d_req = 1'b0; i_req = 1'b0; end
         end
         if (is_d ? d_ack : i_ack) begin
            lat = n; d_req = 1'b0; i_req = 1'b0;
         end
      end
      d_req = 1'b0; i_req = 1'b0;
      check_val({tag, "_latency"}, lat, exp_lat);
      check_val({tag, "_mem_req_cycles"}, mreq, exp_mreq);
      never_ready = 0;
      @(negedge clk);
   endtask

   // Simultaneous D store and I fetch: D first, I's mem_req 2 cycles after d_ack.
   task automatic run_pair(input string tag, input logic [AW-1:0] daddr,
                           input logic [DW-1:0] dwd, input logic [AW-1:0] iaddr);
      int nd, ni, nm;
      nd = 0; ni = 0; nm = 0;
      exp_q.push_back({1'b1, 1'b0, 32'h0});
      mq.push_back({1'b1, daddr, dwd});
      exp_q.push_back({1'b0, 1'b0, mem_arr[iaddr[9:2]]});
      mq.push_back({1'b0, iaddr, 32'h0});
      wait_states = 0;
      never_ready = 0;
      @(negedge clk);
      d_req = 1'b1; d_we = 1'b1; d_addr = daddr; d_wdata = dwd;
      i_req = 1'b1; i_addr = iaddr;
      for (int n = 1; n <= 40 && ni == 0; n++) begin
         @(negedge clk);
         if (d_ack) begin nd = n; d_req = 1'b0; end
         if (nd != 0 && nm == 0 && n > nd && mem_req) nm = n;
         if (i_ack) begin ni = n; i_req = 1'b0; end
      end
      d_req = 1'b0; i_req = 1'b0;
      check_val({tag, "_d_ack_cycle"}, nd, 2);
      check_val({tag, "_i_mem_req_cycle"}, nm, 4);
      check_val({tag, "_i_ack_cycle"}, ni, 5);
      @(negedge clk);
   endtask

   task automatic check_outputs_zero(input string tag);
      check_val({tag, "_mem_req"}, mem_req, 0);
      check_val({tag, "_mem_we"}, mem_we, 0);
      check_val({tag, "_mem_addr"}, mem_addr, 0);
      check_val({tag, "_mem_wdata"}, mem_wdata, 0);
      check_val({tag, "_i_ack"}, i_ack, 0);
      check_val({tag, "_d_ack"}, d_ack, 0);
      check_val({tag, "_err"}, err, 0);
      check_val({tag, "_i_rdata"}, i_rdata, 0);
      check_val({tag, "_d_rdata"}, d_rdata, 0);
   endtask

   // ---------------- watchdog ----------------
   initial begin
      #2000000;
      $display("FAIL watchdog expired");
      $fatal(1, "watchdog");
   end

   // ---------------- main sequence ----------------
   initial begin
      logic [AW-1:0] ra;
      bit rd, rw;
      for (int i = 0; i < 256; i++) mem_arr[i] = 32'h1357_0000 ^ (i * 32'h0101_0101);
      mem_arr[4] = 32'h8C22_0004;

      reset = 1'b1;
      i_req = 1'b0; i_addr = '0;
      d_req = 1'b0; d_we = 1'b0; d_addr = '0; d_wdata = '0;
      @(negedge clk);
      @(negedge clk);
      check_outputs_zero("reset");
      reset = 1'b0;
      @(negedge clk);

      run_txn("fetch_0x10", 1'b0, 1'b0, 32'h10, 32'h0, 0, 0, 1'b0);
      run_txn("store_0x40", 1'b1, 1'b1, 32'h40, 32'hDEADBEEF, 0, 3, 1'b0);
      run_txn("load_0x40",  1'b1, 1'b0, 32'h40, 32'h0, 0, 1, 1'b0);

      run_pair("pair1", 32'h80, 32'hA5A5_0001, 32'h14);
      run_pair("pair2", 32'h84, 32'hA5A5_0002, 32'h18);
      run_pair("pair3", 32'h88, 32'hA5A5_0003, 32'h1C);

      run_txn("misalign_d", 1'b1, 1'b0, 32'h42, 32'h0, 1, 0, 1'b0);
      run_txn("misalign_i", 1'b0, 1'b0, 32'h13, 32'h0, 1, 0, 1'b0);

      run_txn("timeout_d",  1'b1, 1'b0, 32'h44, 32'h0, 2, 0, 1'b0);
      run_txn("after_to",   1'b0, 1'b0, 32'h08, 32'h0, 0, 2, 1'b0);
      run_txn("drop_early", 1'b1, 1'b0, 32'h04, 32'h0, 0, 2, 1'b1);

      for (int k = 0; k < 8; k++) begin
         rd = 1'($urandom_range(0, 1));
         rw = 1'($urandom_range(0, 1));
         ra = {22'h0, 8'($urandom_range(0, 255)), 2'b00};
         run_txn("random", rd, rw, ra, $urandom, 0, $urandom_range(0, 4), 1'b0);
      end

      // Reset in the middle of a 5-wait-state fetch: abandoned, no ack.
      wait_states = 5;
      mq.push_back({1'b0, 32'h20, 32'h0});
      @(negedge clk);
      i_req = 1'b1; i_addr = 32'h20;
      @(negedge clk);
      @(negedge clk);
      @(negedge clk);
      check_val("pre_reset_mem_req", mem_req, 1);
      reset = 1'b1;
      i_req = 1'b0;
      #1;
      check_val("async_reset_mem_req", mem_req, 0);
      check_val("async_reset_i_ack", i_ack, 0);
      mq.delete();
      @(negedge clk);
      @(negedge clk);
      check_outputs_zero("mid_reset");
      reset = 1'b0;
      @(negedge clk);
      check_val("post_reset_no_ack", i_ack | d_ack, 0);
      run_txn("post_reset_fetch", 1'b0, 1'b0, 32'h10, 32'h0, 0, 0, 1'b0);

      @(negedge clk);
      @(negedge clk);
      check_val("exp_q_empty", exp_q.size(), 0);
      check_val("mq_empty", mq.size(), 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
